mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester controller for the shared unified memory (8-bit write data, 16-bit address, 16-bit read word, level `read`, clocked `write`). Arbitrates between the instruction-fetch port (read-only) and the load/store data port, sequences 16-bit stores as two byte writes, and returns a registered read word with a req/ack handshake. Sits between the CPU front-end/LSU and the memory instance.

## Interface
- `ADDR_WIDTH`, 16, memory address width; address increments wrap modulo 2^ADDR_WIDTH
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `f_req`  in  1  fetch read request; held until `f_ack`
- `f_addr`  in  ADDR_WIDTH  fetch address; stable while `f_req`
- `f_ack`  out  1  one-cycle pulse: fetch complete
- `f_rdata`  out  16  fetched word; valid from `f_ack` until next fetch ack
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_byte`  in  1  write size: 1 = byte (`d_wdata[7:0]`), 0 = word
- `d_addr`  in  ADDR_WIDTH  data address
- `d_wdata`  in  16  write data
- `d_ack`  out  1  one-cycle pulse: data access complete
- `d_rdata`  out  16  read word; valid from `d_ack` until next data read ack
- `mem_addr`  out  ADDR_WIDTH  memory address (registered)
- `mem_din`  out  8  memory write byte (registered)
- `mem_read`  out  1  memory read enable (registered)
- `mem_write`  out  1  memory write enable (registered)
- `mem_dout`  in  16  memory read word, combinational on `mem_addr` while `mem_read`

## Operation
- States: IDLE, RD, WR_LO, WR_HI.
- IDLE: sample requests, excluding any port whose ack is high this cycle. Winner's request fields latched; `mem_*` loaded for the next state.
  - fetch → RD; data read → RD; data write → WR_LO.
  - none → stay IDLE, `mem_read`/`mem_write` = 0.
- RD: `mem_read`=1, `mem_addr`=latched address. At the end of the cycle `mem_dout` is captured into the winner's rdata; ack pulses next cycle; → IDLE.
- WR_LO: `mem_write`=1, `mem_addr`=addr, `mem_din`=wdata[7:0].
  - If byte write: ack next cycle; → IDLE.
  - Else → WR_HI.
- WR_HI: `mem_write`=1, `mem_addr`=addr+1 (0xFFFF → 0x0000), `mem_din`=wdata[15:8]; ack next cycle; → IDLE.
- Arbitration: round-robin on simultaneous requests. The port not granted last wins. `last_grant` resets to data, so fetch wins the first tie.
- Only the granted port's ack/rdata change; the other port's rdata holds.

## Timing
- Reset (edge with `rst_n`=0): state IDLE, all outputs 0, `last_grant`=data.
- Reset mid-operation: strobes drop at the same edge, no ack is issued, and the transaction is abandoned. A word write may leave the low byte written.
- Read latency: req seen at edge N → RD during cycle N..N+1 → ack and rdata valid in cycle N+1..N+2.
- Byte write: 2 cycles, req to ack. Word write: 3 cycles, req to ack.
- Requester must deassert req, or present a new request, in the ack cycle. Arbiter ignores the acking port in that cycle, so back-to-back same-port accesses have one idle cycle.
- Other-port request pending during an ack cycle is granted in that cycle (no idle gap).
- `mem_read` and `mem_write` are never high together.

## Configuration
- `MEM_ARB_DATA_PRIORITY_EN` defined: fixed priority; data port always wins simultaneous requests; `last_grant` unused.
- Undefined: round-robin as above.

## Test plan
- Reset: hold `rst_n`=0 two cycles with `f_req`=1 → all outputs 0, no ack; release → fetch granted, RD at next edge.
- Fetch read: `f_addr`=0x0002, memory word 0x1234 → `mem_read`=1 with `mem_addr`=0x0002 for one cycle; `f_ack` next cycle with `f_rdata`=0x1234.
- Word write: `d_we`=1, `d_byte`=0, `d_addr`=0xFFFF, `d_wdata`=0xBEEF → writes 0xEF@0xFFFF then 0xBE@0x0000; `d_ack` 3 cycles after req.
- Byte write then read: write 0x03@0x0002 (`d_byte`=1), then data read 0x0002 → single `mem_write` cycle; `d_rdata[7:0]`=0x03.
- Contention: `f_req` and `d_req` held continuously →
  - default: grants alternate fetch, data, fetch…
  - with `MEM_ARB_DATA_PRIORITY_EN`: data is always granted while `d_req` is re-asserted.
- Mid-write reset: assert `rst_n`=0 during WR_HI → `mem_write`=0 at that edge, no `d_ack`, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter for the shared unified memory: round-robin grant,
// word stores split into two byte writes. Define MEM_ARB_DATA_PRIORITY_EN for fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ack,
  output logic [15:0]           f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic                  d_byte,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_ack,
  output logic [15:0]           d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [15:0]           mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  sel_data_reg, sel_data_next;
  logic                  byte_reg, byte_next;
  logic [7:0]            wdata_hi_reg, wdata_hi_next;
  logic                  f_ack_reg, f_ack_next;
  logic                  d_ack_reg, d_ack_next;
  logic [15:0]           f_rdata_reg, f_rdata_next;
  logic [15:0]           d_rdata_reg, d_rdata_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]            mem_din_reg, mem_din_next;
  logic                  mem_read_reg, mem_read_next;
  logic                  mem_write_reg, mem_write_next;

  logic f_cand, d_cand, grant_data;

`ifndef MEM_ARB_DATA_PRIORITY_EN
  // 1 = data port was granted most recently
  logic last_grant_reg, last_grant_next;
`endif

  // A port whose ack is high this cycle is presenting a fresh request that must wait a cycle.
  always_comb begin
    f_cand = f_req & ~f_ack_reg;
    d_cand = d_req & ~d_ack_reg;
    if (f_cand && d_cand) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
      grant_data = 1'b1;
`else
      grant_data = ~last_grant_reg;
`endif
    end else begin
      grant_data = d_cand;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_data_next  = sel_data_reg;
    byte_next      = byte_reg;
    wdata_hi_next  = wdata_hi_reg;
    f_ack_next     = 1'b0;
    d_ack_next     = 1'b0;
    f_rdata_next   = f_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    mem_addr_next  = mem_addr_reg;
    mem_din_next   = mem_din_reg;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
`ifndef MEM_ARB_DATA_PRIORITY_EN
    last_grant_next = last_grant_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (f_cand || d_cand) begin
          sel_data_next = grant_data;
`ifndef MEM_ARB_DATA_PRIORITY_EN
          last_grant_next = grant_data;
`endif
          mem_addr_next = grant_data ? d_addr : f_addr;
          if (grant_data && d_we) begin
            state_next     = WR_LO;
            byte_next      = d_byte;
            wdata_hi_next  = d_wdata[15:8];
            mem_din_next   = d_wdata[7:0];
            mem_write_next = 1'b1;
          end else begin
            state_next    = RD;
            mem_read_next = 1'b1;
          end
        end
      end

      RD: begin
        if (sel_data_reg) begin
          d_rdata_next = mem_dout;
          d_ack_next   = 1'b1;
        end else begin
          f_rdata_next = mem_dout;
          f_ack_next   = 1'b1;
        end
        state_next = IDLE;
      end

      WR_LO: begin
        if (byte_reg) begin
          d_ack_next = 1'b1;
          state_next = IDLE;
        end else begin
          // High byte goes to the next address, wrapping at the top of memory.
          mem_addr_next  = mem_addr_reg + ADDR_WIDTH'(1);
          mem_din_next   = wdata_hi_reg;
          mem_write_next = 1'b1;
          state_next     = WR_HI;
        end
      end

      WR_HI: begin
        d_ack_next = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_data_reg  <= 1'b0;
      byte_reg      <= 1'b0;
      wdata_hi_reg  <= 8'h00;
      f_ack_reg     <= 1'b0;
      d_ack_reg     <= 1'b0;
      f_rdata_reg   <= 16'h0000;
      d_rdata_reg   <= 16'h0000;
      mem_addr_reg  <= '0;
      mem_din_reg   <= 8'h00;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
`ifndef MEM_ARB_DATA_PRIORITY_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      state_reg     <= state_next;
      sel_data_reg  <= sel_data_next;
      byte_reg      <= byte_next;
      wdata_hi_reg  <= wdata_hi_next;
      f_ack_reg     <= f_ack_next;
      d_ack_reg     <= d_ack_next;
      f_rdata_reg   <= f_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      mem_addr_reg  <= mem_addr_next;
      mem_din_reg   <= mem_din_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
`ifndef MEM_ARB_DATA_PRIORITY_EN
      last_grant_reg <= last_grant_next;
`endif
    end
  end

  assign f_ack     = f_ack_reg;
  assign f_rdata   = f_rdata_reg;
  assign d_ack     = d_ack_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_din   = mem_din_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;

endmodule
